// File: rtl/data_mem_responder_if.sv
// Load/store data-memory bus between the core (master) and a memory responder (slave).
// Latency: none, wires only.
// Backpressure: the responder completes each request with a ready or error pulse.
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 13
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           write_data;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           read_data;
    logic                  ready;
    logic                  error;

    modport master (
        output addr, write_data, mem_read, mem_write,
        input  read_data, ready, error
    );

    modport slave (
        input  addr, write_data, mem_read, mem_write,
        output read_data, ready, error
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated word memory answering the core's load/store port, flagging illegal requests.
// Latency: ready/error pulse in cycle accept+WAIT_CYCLES+1 (error: accept+1).
// Backpressure: one transaction at a time; inputs are ignored from accept until back in IDLE.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 13,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, ERR} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [DEPTH_LOG2-1:0]   lat_idx;
    logic [31:0]             lat_wdata;
    logic                    lat_write;
    logic [31:0]             mem [DEPTH];
    logic [31:0]             read_data_q;
    logic                    ready_q;
    logic                    error_q;

    logic                    req;
    logic                    illegal;
    logic [ADDR_WIDTH-3:0]   word_addr;
    logic                    acc_en;
    logic                    acc_write;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [31:0]             acc_wdata;

    assign req       = bus.mem_read | bus.mem_write;
    assign word_addr = bus.addr[ADDR_WIDTH-1:2];
    // Any word address bit at or above DEPTH_LOG2 puts the request past the last stored word.
    assign illegal   = (bus.mem_read & bus.mem_write)
                     | (bus.addr[1:0] != 2'b00)
                     | ((word_addr >> DEPTH_LOG2) != '0);

    // Next state, wait counting, and selection of the access performed at this edge.
    // With zero wait states the access happens at the accept edge, so it uses the live inputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_en    = 1'b0;
        acc_write = lat_write;
        acc_idx   = lat_idx;
        acc_wdata = lat_wdata;
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        state_nxt = ERR;
                    end else if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                        acc_en    = 1'b1;
                        acc_write = bus.mem_write;
                        acc_idx   = bus.addr[DEPTH_LOG2+1:2];
                        acc_wdata = bus.write_data;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = '0;
                    end
                end
            end
            WAIT: begin
                if (cnt == CW'(WAIT_CYCLES - 1)) begin
                    state_nxt = RESP;
                    acc_en    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter, request latch and the registered ready/error/read_data outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_idx     <= '0;
            lat_wdata   <= '0;
            lat_write   <= 1'b0;
            read_data_q <= '0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == RESP);
            error_q <= (state_nxt == ERR);
            if (state == IDLE && req) begin
                lat_idx   <= bus.addr[DEPTH_LOG2+1:2];
                lat_wdata <= bus.write_data;
                lat_write <= bus.mem_write;
            end
            if (acc_en && !acc_write) begin
                read_data_q <= mem[acc_idx];
            end
        end
    end

    // Word storage; reset clears every word so an aborted write leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (acc_en && acc_write) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.read_data = read_data_q;
    assign bus.ready     = ready_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance.
// Expected responses are queued at issue time; negedge monitors pop and compare.
// Every transaction is checked for kind, response cycle and read_data.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;

    data_mem_responder_if #(.ADDR_WIDTH(13)) bus0 ();
    data_mem_responder_if #(.ADDR_WIDTH(13)) bus1 ();

    data_mem_responder #(.ADDR_WIDTH(13), .DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut_w2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    data_mem_responder #(.ADDR_WIDTH(13), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut_w0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic check_out(input int inst, input logic rdy, input logic err, input logic [31:0] rd);
        exp_t e;
        if (!(rdy === 1'b1 || err === 1'b1)) return;
        compared++;
        if (rdy && err) begin
            mismatched++;
            $display("FAIL both_high inst%0d cyc %0d: ready=1 error=1, required one of them", inst, cyc);
            return;
        end
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            mismatched++;
            $display("FAIL unexpected inst%0d cyc %0d: ready=%0b error=%0b, required no response", inst, cyc, rdy, err);
            return;
        end
        if (inst == 0) e = q0.pop_front();
        else           e = q1.pop_front();
        if (err !== e.is_err || cyc != e.cyc) begin
            mismatched++;
            $display("FAIL kind_cycle inst%0d: got error=%0b at cyc %0d, required error=%0b at cyc %0d",
                     inst, err, cyc, e.is_err, e.cyc);
        end
        compared++;
        if (rd !== e.data) begin
            mismatched++;
            $display("FAIL read_data inst%0d cyc %0d: got 0x%08h, required 0x%08h", inst, cyc, rd, e.data);
        end
    endtask

    always @(negedge clk) check_out(0, bus0.ready, bus0.error, bus0.read_data);
    always @(negedge clk) check_out(1, bus1.ready, bus1.error, bus1.read_data);

    task automatic drive(input int inst, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [31:0] wd);
        if (inst == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.write_data = wd;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.write_data = wd;
        end
    endtask

    // Called 1 unit after a rising edge; request is accepted at the next edge, then dropped
    // with scrambled address/data so that latched fields are what the DUT must use.
    task automatic issue(input int inst, input logic rd, input logic wr,
                         input logic [12:0] a, input logic [31:0] wd,
                         input logic exp_err, input logic [31:0] exp_data, input int w);
        exp_t e;
        drive(inst, rd, wr, a, wd);
        @(posedge clk); #1;
        e.is_err = exp_err;
        e.data   = exp_data;
        e.cyc    = exp_err ? cyc : cyc + w;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
        drive(inst, 1'b0, 1'b0, a ^ 13'h0FF4, ~wd);
        repeat (w + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 13'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 13'h0, 32'h0);

        // Asynchronous reset pulse in the middle of a cycle.
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("rst_ready0", {31'b0, bus0.ready}, 32'h0);
        chk("rst_error0", {31'b0, bus0.error}, 32'h0);
        chk("rst_rdata0", bus0.read_data, 32'h0);
        chk("rst_ready1", {31'b0, bus1.ready}, 32'h0);
        chk("rst_error1", {31'b0, bus1.error}, 32'h0);
        chk("rst_rdata1", bus1.read_data, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'b0, bus0.ready | bus1.ready}, 32'h0);
            chk("idle_error", {31'b0, bus0.error | bus1.error}, 32'h0);
        end
        @(posedge clk); #1;

        // 2-wait-state instance: basic store/load, illegal requests, boundary word.
        issue(0, 0, 1, 13'h010, 32'hDEADBEEF, 0, 32'h00000000, 2);
        issue(0, 1, 0, 13'h010, 32'h0,        0, 32'hDEADBEEF, 2);
        issue(0, 1, 0, 13'h014, 32'h0,        0, 32'h00000000, 2);
        issue(0, 1, 0, 13'h010, 32'h0,        0, 32'hDEADBEEF, 2);
        issue(0, 1, 1, 13'h020, 32'h11111111, 1, 32'hDEADBEEF, 2);
        issue(0, 1, 0, 13'h013, 32'h0,        1, 32'hDEADBEEF, 2);
        issue(0, 0, 1, 13'h400, 32'h22222222, 1, 32'hDEADBEEF, 2);
        issue(0, 1, 0, 13'h000, 32'h0,        0, 32'h00000000, 2);
        issue(0, 0, 1, 13'h3FC, 32'h0BADF00D, 0, 32'h00000000, 2);
        issue(0, 1, 0, 13'h3FC, 32'h0,        0, 32'h0BADF00D, 2);
        // Request dropped and address changed during WAIT (done inside issue).
        issue(0, 0, 1, 13'h008, 32'h12345678, 0, 32'h0BADF00D, 2);
        issue(0, 1, 0, 13'h008, 32'h0,        0, 32'h12345678, 2);

        // Reset during the WAIT of a store: no ready, nothing committed, storage cleared.
        drive(0, 1'b0, 1'b1, 13'h00C, 32'hCAFEF00D);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 13'h000, 32'h0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, bus0.ready}, 32'h0);
        chk("midrst_rdata", bus0.read_data, 32'h0);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        issue(0, 1, 0, 13'h00C, 32'h0, 0, 32'h00000000, 2);
        issue(0, 1, 0, 13'h3FC, 32'h0, 0, 32'h00000000, 2);

        // 0-wait-state instance: back-to-back at a 2-cycle interval.
        issue(1, 0, 1, 13'h004, 32'hA5A55A5A, 0, 32'h00000000, 0);
        issue(1, 1, 0, 13'h004, 32'h0,        0, 32'hA5A55A5A, 0);
        issue(1, 1, 0, 13'h006, 32'h0,        1, 32'hA5A55A5A, 0);
        issue(1, 1, 0, 13'h000, 32'h0,        0, 32'h00000000, 0);

        repeat (6) @(posedge clk);
        @(negedge clk); #1;
        chk("pending_q0", q0.size(), 32'h0);
        chk("pending_q1", q1.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
